// File: rtl/wfq_pkg.sv
// Shared definitions for the WFQ descriptor queue block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wfq_pkg;

    // Queue index width; must agree with the wfq_sched instance it pairs with.
    localparam int WFQ_QUEUE_NUM_WIDTH = 2;

    // Grant FSM: request an arbitration, wait for the grant, hold the popped
    // descriptor until the egress side takes it.
    typedef enum logic [1:0] {
        WFQ_IDLE     = 2'd0,
        WFQ_WAIT_GNT = 2'd1,
        WFQ_HOLD     = 2'd2
    } wfq_state_e;

endpackage

// File: rtl/wfq_desc_fifo.sv
// Single descriptor FIFO, depth 2**DEPTH_WIDTH, head visible combinationally.
// Latency: push visible at dout/count one cycle after the accepting edge.
// Backpressure: push ignored when full, pop ignored when empty (no look-ahead).
//
// Ports: clk/rst (sync, active-high), push/din write side, pop/dout head read
// side, count (0..depth), full, empty.
module wfq_desc_fifo #(
    parameter int DESC_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DESC_WIDTH-1:0] din,
    output logic [DESC_WIDTH-1:0] dout,
    output logic [DEPTH_WIDTH:0]  count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DESC_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   cnt;
    logic                   push_ok;
    logic                   pop_ok;

    assign full    = (cnt == (DEPTH_WIDTH+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally at DEPTH_WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wfq_desc_queues.sv
// Per-queue descriptor buffers feeding wfq_sched; pops the granted queue head.
// Latency: grant in cycle W -> deq_vld from W+1; one descriptor per 3 cycles peak.
// Backpressure: enq_rdy = target queue not full; deq_dat held until deq_rdy.
//
// Ports: enq_vld/enq_qid/enq_desc/enq_rdy classifier side; wfq_rdy/wfq_sch_en
// request side and wfq_winner_vld/wfq_winner grant side of the scheduler;
// deq_vld/deq_qid/deq_desc/deq_rdy egress side; wfq_err sticky bad-grant flag.
module wfq_desc_queues
    import wfq_pkg::*;
#(
    parameter int QUEUE_NUM_WIDTH = WFQ_QUEUE_NUM_WIDTH,
    parameter int DESC_WIDTH      = 16,
    parameter int DEPTH_WIDTH     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_vld,
    input  logic [QUEUE_NUM_WIDTH-1:0] enq_qid,
    input  logic [DESC_WIDTH-1:0]      enq_desc,
    output logic                       enq_rdy,
    output logic [(1<<QUEUE_NUM_WIDTH)-1:0] wfq_rdy,
    output logic                       wfq_sch_en,
    input  logic                       wfq_winner_vld,
    input  logic [QUEUE_NUM_WIDTH-1:0] wfq_winner,
    output logic                       deq_vld,
    output logic [QUEUE_NUM_WIDTH-1:0] deq_qid,
    output logic [DESC_WIDTH-1:0]      deq_desc,
    input  logic                       deq_rdy,
    output logic                       wfq_err
);

    localparam int QUEUE_NUM = 1 << QUEUE_NUM_WIDTH;

    logic [QUEUE_NUM-1:0]  fifo_push;
    logic [QUEUE_NUM-1:0]  fifo_pop;
    logic [QUEUE_NUM-1:0]  fifo_full;
    logic [QUEUE_NUM-1:0]  fifo_empty;
    logic [DESC_WIDTH-1:0] fifo_head  [QUEUE_NUM];
    logic [DEPTH_WIDTH:0]  fifo_count [QUEUE_NUM];

    wfq_state_e state;
    wfq_state_e state_nxt;
    logic       grant_hit;
    logic       pop_fire;
    logic       err_set;

    // No look-ahead at a same-cycle pop: a full queue refuses the write.
    assign enq_rdy   = ~fifo_full[enq_qid];
    // Registered counts only, so a same-cycle enqueue into an empty queue
    // cannot satisfy a grant.
    assign grant_hit = (fifo_count[wfq_winner] != '0);
    assign deq_vld   = (state == WFQ_HOLD);

    for (genvar g = 0; g < QUEUE_NUM; g++) begin : g_queue
        assign fifo_push[g] = enq_vld && enq_rdy && (enq_qid == QUEUE_NUM_WIDTH'(g));
        assign fifo_pop[g]  = pop_fire && (wfq_winner == QUEUE_NUM_WIDTH'(g));
        assign wfq_rdy[g]   = ~fifo_empty[g];

        wfq_desc_fifo #(
            .DESC_WIDTH  (DESC_WIDTH),
            .DEPTH_WIDTH (DEPTH_WIDTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (enq_desc),
            .dout  (fifo_head[g]),
            .count (fifo_count[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WFQ_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        wfq_sch_en = 1'b0;
        pop_fire   = 1'b0;
        err_set    = 1'b0;
        case (state)
            WFQ_IDLE: begin
                // Grants arriving here are stale and ignored.
                wfq_sch_en = |wfq_rdy;
                if (wfq_sch_en) state_nxt = WFQ_WAIT_GNT;
            end
            WFQ_WAIT_GNT: begin
                if (wfq_winner_vld) begin
                    if (grant_hit) begin
                        pop_fire  = 1'b1;
                        state_nxt = WFQ_HOLD;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = WFQ_IDLE;
                    end
                end
            end
            WFQ_HOLD: begin
                if (deq_rdy) state_nxt = WFQ_IDLE;
            end
            default: state_nxt = WFQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deq_desc <= '0;
            deq_qid  <= '0;
            wfq_err  <= 1'b0;
        end else begin
            if (pop_fire) begin
                deq_desc <= fifo_head[wfq_winner];
                deq_qid  <= wfq_winner;
            end
            if (err_set) wfq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wfq_desc_queues.sv
// Directed bench for wfq_desc_queues with hand-computed expected values.
// Latency: checks deq one cycle after grant, wfq_rdy one cycle after enqueue.
// Backpressure: exercises full-queue refusal and deq_rdy held low in HOLD.
module tb_wfq_desc_queues;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_vld;
    logic [1:0]  enq_qid;
    logic [15:0] enq_desc;
    logic        enq_rdy;
    logic [3:0]  wfq_rdy;
    logic        wfq_sch_en;
    logic        wfq_winner_vld;
    logic [1:0]  wfq_winner;
    logic        deq_vld;
    logic [1:0]  deq_qid;
    logic [15:0] deq_desc;
    logic        deq_rdy;
    logic        wfq_err;

    int checks   = 0;
    int failures = 0;
    int sch_cnt  = 0;
    int sch_used = 0;
    int snap;

    always #5 clk = ~clk;

    wfq_desc_queues dut (
        .clk            (clk),
        .rst            (rst),
        .enq_vld        (enq_vld),
        .enq_qid        (enq_qid),
        .enq_desc       (enq_desc),
        .enq_rdy        (enq_rdy),
        .wfq_rdy        (wfq_rdy),
        .wfq_sch_en     (wfq_sch_en),
        .wfq_winner_vld (wfq_winner_vld),
        .wfq_winner     (wfq_winner),
        .deq_vld        (deq_vld),
        .deq_qid        (deq_qid),
        .deq_desc       (deq_desc),
        .deq_rdy        (deq_rdy),
        .wfq_err        (wfq_err)
    );

    // Count arbitration requests away from the active edge.
    always @(negedge clk) begin
        if (wfq_sch_en === 1'b1) sch_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] q, input logic [15:0] d);
        enq_vld  = 1'b1;
        enq_qid  = q;
        enq_desc = d;
        step();
        enq_vld  = 1'b0;
    endtask

    // Wait (bounded) until an unconsumed request pulse has been seen; the FSM
    // is then in WAIT_GNT.
    task automatic wait_req();
        int n;
        n = 0;
        while (sch_cnt <= sch_used && n < 50) begin
            step();
            n++;
        end
        chk("req_timeout", (sch_cnt > sch_used) ? 32'd1 : 32'd0, 32'd1);
        sch_used++;
    endtask

    task automatic grant_chk(input logic [1:0] q, input logic [15:0] exp);
        wfq_winner_vld = 1'b1;
        wfq_winner     = q;
        step();
        wfq_winner_vld = 1'b0;
        chk("deq_vld_hold", deq_vld, 1);
        chk("deq_desc", deq_desc, exp);
        chk("deq_qid", deq_qid, q);
        step();
        chk("deq_vld_drop", deq_vld, 0);
    endtask

    task automatic serve(input logic [1:0] q, input logic [15:0] exp);
        wait_req();
        step();
        grant_chk(q, exp);
    endtask

    initial begin
        rst = 1'b1; enq_vld = 1'b0; enq_qid = '0; enq_desc = '0;
        wfq_winner_vld = 1'b0; wfq_winner = '0; deq_rdy = 1'b1;
        step(); step();
        rst = 1'b0;

        // Reset, no traffic
        chk("rst_wfq_rdy", wfq_rdy, 0);
        chk("rst_sch_en", wfq_sch_en, 0);
        chk("rst_enq_rdy", enq_rdy, 1);
        chk("rst_deq_vld", deq_vld, 0);
        chk("rst_deq_qid", deq_qid, 0);
        chk("rst_deq_desc", deq_desc, 0);
        chk("rst_err", wfq_err, 0);
        repeat (4) step();
        chk("idle_no_req", sch_cnt, 0);

        // Single descriptor through queue 2
        enq(2'd2, 16'hA001);
        chk("q2_rdy", wfq_rdy, 4'b0100);
        chk("q2_sch_en", wfq_sch_en, 1);
        serve(2'd2, 16'hA001);
        chk("q2_rdy_fall", wfq_rdy, 0);

        // Fill queue 1, then drain through pointer wrap while refilling
        for (int k = 0; k < 8; k++) enq(2'd1, 16'h0100 + 16'(k));
        enq_qid = 2'd1;
        #1 chk("q1_full_enq_rdy", enq_rdy, 0);
        enq_qid = 2'd0;
        #1 chk("q0_enq_rdy", enq_rdy, 1);
        enq(2'd1, 16'h01FF);  // refused: queue 1 full
        chk("q1_rdy", wfq_rdy, 4'b0010);
        for (int k = 0; k < 16; k++) begin
            serve(2'd1, 16'h0100 + 16'(k));
            if (k < 8) enq(2'd1, 16'h0108 + 16'(k));
        end
        chk("q1_drained", wfq_rdy, 0);

        // Same-cycle enqueue and pop on queue 3
        enq(2'd3, 16'h3001);
        wait_req();
        step();
        wfq_winner_vld = 1'b1; wfq_winner = 2'd3;
        enq_vld = 1'b1; enq_qid = 2'd3; enq_desc = 16'h3002;
        step();
        wfq_winner_vld = 1'b0; enq_vld = 1'b0;
        chk("q3_pop_desc", deq_desc, 16'h3001);
        chk("q3_count_kept", wfq_rdy, 4'b1000);
        step();
        serve(2'd3, 16'h3002);
        chk("q3_empty", wfq_rdy, 0);

        // Grant naming empty queue 0
        enq(2'd1, 16'h1111);
        wait_req();
        step();
        wfq_winner_vld = 1'b1; wfq_winner = 2'd0;
        step();
        wfq_winner_vld = 1'b0;
        chk("err_set", wfq_err, 1);
        chk("err_no_deq", deq_vld, 0);
        chk("err_no_pop", wfq_rdy, 4'b0010);
        chk("err_rereq", wfq_sch_en, 1);
        serve(2'd1, 16'h1111);
        chk("err_sticky", wfq_err, 1);

        // Hold with deq_rdy low, then reset mid-operation
        enq(2'd0, 16'h0AAA);
        enq(2'd2, 16'h0BBB);
        deq_rdy = 1'b0;
        wait_req();
        step();
        wfq_winner_vld = 1'b1; wfq_winner = 2'd0;
        step();
        wfq_winner_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_vld", deq_vld, 1);
            chk("hold_desc", deq_desc, 16'h0AAA);
            chk("hold_qid", deq_qid, 0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        deq_rdy = 1'b1;
        chk("mid_rst_deq_vld", deq_vld, 0);
        chk("mid_rst_desc", deq_desc, 0);
        chk("mid_rst_qid", deq_qid, 0);
        chk("mid_rst_err", wfq_err, 0);
        chk("mid_rst_wfq_rdy", wfq_rdy, 0);
        chk("mid_rst_enq_rdy", enq_rdy, 1);
        snap = sch_cnt;
        repeat (4) step();
        chk("mid_rst_no_req", sch_cnt, snap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
